imm_decode_stage: RTL and testbench

- Parametrised, pipelined successor to the combinational immediate generator.
- Accepts 32-bit RV instructions over a valid/ready handshake and decodes the instruction format.
- Produces the XLEN-wide sign-/zero-extended immediate plus an illegal-opcode flag.
- Sits between fetch and register-read; a 2-entry skid buffer lets it absorb backend stalls without a combinational ready path.

---
 rtl/imm_decode_stage.sv | 177 +++++++++++++++++
 tb/tb_imm_decode_stage.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_decode_stage.sv
// Purpose: decodes RV instruction format and XLEN-wide immediate, buffered in a 2-entry skid FIFO.
// Latency: 1 cycle from accept to out_valid.
// Backpressure: in_ready is a function of occupancy only (low when both entries are full).
module imm_decode_stage #(
    parameter int XLEN = 32,
    parameter int PC_W = XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal,
    output logic [31:0]     out_instr,
    output logic [PC_W-1:0] out_pc
);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic              pop;
    logic              ld_head_new;
    logic              ld_head_skid;
    logic              ld_skid;

    logic [6:0]        opcode;
    logic [2:0]        dec_fmt;
    logic [XLEN-1:0]   dec_imm;
    logic [XLEN-1:0]   imm_i;
    logic [XLEN-1:0]   imm_s;
    logic [XLEN-1:0]   imm_b;
    logic [XLEN-1:0]   imm_u;
    logic [XLEN-1:0]   imm_j;
    logic [XLEN-1:0]   imm_z;

    logic [XLEN-1:0]   skid_imm;
    logic [2:0]        skid_fmt;
    logic [31:0]       skid_instr;
    logic [PC_W-1:0]   skid_pc;

    assign in_ready    = (state != TWO);
    assign out_valid   = (state != EMPTY);
    assign accept      = in_valid & in_ready;
    assign pop         = out_valid & out_ready;
    assign out_illegal = (out_fmt == FMT_ILL);

    // Immediate fields, each sign-extended from its own top bit (U included).
    assign opcode = in_instr[6:0];
    assign imm_i  = {{(XLEN-11){in_instr[31]}}, in_instr[30:20]};
    assign imm_s  = {{(XLEN-11){in_instr[31]}}, in_instr[30:25], in_instr[11:7]};
    assign imm_b  = {{(XLEN-12){in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u  = {{(XLEN-31){in_instr[31]}}, in_instr[30:12], 12'b0};
    assign imm_j  = {{(XLEN-20){in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
    assign imm_z  = {{(XLEN-5){1'b0}}, in_instr[19:15]};

    // Format classification and immediate selection; RV64-only opcodes are illegal at XLEN=32.
    always_comb begin
        dec_fmt = FMT_ILL;
        dec_imm = '0;
        if (in_instr[1:0] == 2'b11) begin
            case (opcode)
                7'b1100111, 7'b0000011, 7'b0010011, 7'b1110011: dec_fmt = FMT_I;
                7'b0011011: dec_fmt = (XLEN == 64) ? FMT_I : FMT_ILL;
                7'b0100011: dec_fmt = FMT_S;
                7'b1100011: dec_fmt = FMT_B;
                7'b0110111, 7'b0010111: dec_fmt = FMT_U;
                7'b1101111: dec_fmt = FMT_J;
                7'b0110011, 7'b0001111: dec_fmt = FMT_R;
                7'b0111011: dec_fmt = (XLEN == 64) ? FMT_R : FMT_ILL;
                default: dec_fmt = FMT_ILL;
            endcase
        end
        case (dec_fmt)
            FMT_I:   dec_imm = (opcode == 7'b1110011 && in_instr[14]) ? imm_z : imm_i;
            FMT_S:   dec_imm = imm_s;
            FMT_B:   dec_imm = imm_b;
            FMT_U:   dec_imm = imm_u;
            FMT_J:   dec_imm = imm_j;
            default: dec_imm = '0;
        endcase
    end

    // Occupancy register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nxt;
    end

    // Next occupancy and entry-load strobes; flush overrides accept and pop.
    always_comb begin
        state_nxt    = state;
        ld_head_new  = 1'b0;
        ld_head_skid = 1'b0;
        ld_skid      = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_nxt   = ONE;
                        ld_head_new = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        ld_head_new = 1'b1;
                    end else if (accept) begin
                        state_nxt = TWO;
                        ld_skid   = 1'b1;
                    end else if (pop) begin
                        state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state_nxt    = ONE;
                        ld_head_skid = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // Head entry: drives the outputs, so it only changes on fill or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_imm   <= '0;
            out_fmt   <= '0;
            out_instr <= '0;
            out_pc    <= '0;
        end else if (ld_head_new) begin
            out_imm   <= dec_imm;
            out_fmt   <= dec_fmt;
            out_instr <= in_instr;
            out_pc    <= in_pc;
        end else if (ld_head_skid) begin
            out_imm   <= skid_imm;
            out_fmt   <= skid_fmt;
            out_instr <= skid_instr;
            out_pc    <= skid_pc;
        end
    end

    // Skid entry: catches the accepted instruction while the head is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_imm   <= '0;
            skid_fmt   <= '0;
            skid_instr <= '0;
            skid_pc    <= '0;
        end else if (ld_skid) begin
            skid_imm   <= dec_imm;
            skid_fmt   <= dec_fmt;
            skid_instr <= in_instr;
            skid_pc    <= in_pc;
        end
    end

endmodule

// File: tb/tb_imm_decode_stage.sv
// Purpose: checks imm_decode_stage at XLEN=32 and XLEN=64 against a queue-based reference model.
// Latency: expects outputs 1 cycle after accept.
// Backpressure: model in_ready is derived from model queue depth (< 2).
module tb_imm_decode_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;

    logic        r32, v32, ill32;
    logic [31:0] imm32, ins32, pc32;
    logic [2:0]  fmt32;
    logic        r64, v64, ill64;
    logic [63:0] imm64, pc64;
    logic [31:0] ins64;
    logic [2:0]  fmt64;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct { logic [31:0] instr; logic [63:0] pc; } ent_t;
    ent_t q[$];
    bit   zero_exp;

    imm_decode_stage #(.XLEN(32), .PC_W(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(r32), .in_instr(in_instr), .in_pc(in_pc[31:0]),
        .out_valid(v32), .out_ready(out_ready), .out_imm(imm32), .out_fmt(fmt32),
        .out_illegal(ill32), .out_instr(ins32), .out_pc(pc32)
    );

    imm_decode_stage #(.XLEN(64), .PC_W(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(r64), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(v64), .out_ready(out_ready), .out_imm(imm64), .out_fmt(fmt64),
        .out_illegal(ill64), .out_instr(ins64), .out_pc(pc64)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic longint sx(input longint f, input int b);
        return (f <<< (64 - b)) >>> (64 - b);
    endfunction

    // Reference decode written from the field tables using plain integer arithmetic.
    function automatic void mdec(input logic [31:0] w, input int xl,
                                 output logic [63:0] imm, output logic [2:0] fmt);
        longint v;
        int op;
        op  = int'(w[6:0]);
        fmt = 3'd7;
        v   = 0;
        if (w[1:0] == 2'b11) begin
            if (op == 'h67 || op == 'h03 || op == 'h13 || op == 'h73 || (op == 'h1B && xl == 64)) begin
                fmt = 3'd1;
                if (op == 'h73 && w[14]) v = longint'(w[19:15]);
                else                     v = sx(longint'(w[31:20]), 12);
            end else if (op == 'h23) begin
                fmt = 3'd2;
                v = sx((longint'(w[31:25]) << 5) + longint'(w[11:7]), 12);
            end else if (op == 'h63) begin
                fmt = 3'd3;
                v = sx((longint'(w[31]) << 12) + (longint'(w[7]) << 11)
                       + (longint'(w[30:25]) << 5) + (longint'(w[11:8]) << 1), 13);
            end else if (op == 'h37 || op == 'h17) begin
                fmt = 3'd4;
                v = sx(longint'(w[31:12]) * 4096, 32);
            end else if (op == 'h6F) begin
                fmt = 3'd5;
                v = sx((longint'(w[31]) << 20) + (longint'(w[19:12]) << 12)
                       + (longint'(w[20]) << 11) + (longint'(w[30:21]) << 1), 21);
            end else if (op == 'h33 || op == 'h0F || (op == 'h3B && xl == 64)) begin
                fmt = 3'd0;
            end
        end
        imm = 64'(v);
        if (xl == 32) imm[63:32] = 32'h0;
    endfunction

    // Model state update on each clock edge; reset empties it at once.
    always @(posedge clk or negedge rst_n) begin
        bit acc;
        bit pp;
        if (!rst_n) begin
            q.delete();
            zero_exp = 1'b1;
        end else if (flush) begin
            q.delete();
        end else begin
            acc = in_valid && (q.size() < 2);
            pp  = (q.size() > 0) && out_ready;
            if (pp) void'(q.pop_front());
            if (acc) begin
                q.push_back('{instr: in_instr, pc: in_pc});
                zero_exp = 1'b0;
            end
        end
    end

    // Compare both DUTs against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        logic [63:0] ei;
        logic [2:0]  ef;
        check("in_ready32", r32, q.size() < 2);
        check("in_ready64", r64, q.size() < 2);
        check("out_valid32", v32, q.size() > 0);
        check("out_valid64", v64, q.size() > 0);
        if (q.size() > 0) begin
            mdec(q[0].instr, 32, ei, ef);
            check("imm32", imm32, ei);
            check("fmt32", fmt32, ef);
            check("illegal32", ill32, ef == 3'd7);
            check("instr32", ins32, q[0].instr);
            check("pc32", pc32, q[0].pc[31:0]);
            mdec(q[0].instr, 64, ei, ef);
            check("imm64", imm64, ei);
            check("fmt64", fmt64, ef);
            check("illegal64", ill64, ef == 3'd7);
            check("instr64", ins64, q[0].instr);
            check("pc64", pc64, q[0].pc);
        end else if (zero_exp) begin
            check("zero32", {imm32, fmt32, ill32, ins32, pc32}, 64'h0);
            check("zero64", {fmt64, ill64, ins64}, 64'h0);
            check("zero64_imm", imm64, 64'h0);
            check("zero64_pc", pc64, 64'h0);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] w, input logic [63:0] pc);
        in_valid = 1'b1;
        in_instr = w;
        in_pc    = pc;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [13];
        logic [31:0] w;
        ops = '{7'h67, 7'h03, 7'h13, 7'h73, 7'h1B, 7'h23, 7'h63,
                7'h37, 7'h17, 7'h6F, 7'h33, 7'h0F, 7'h3B};
        w = $urandom;
        if ($urandom_range(9) < 8) w[6:0] = ops[$urandom_range(12)];
        return w;
    endfunction

    initial begin
        logic [63:0] mi;
        logic [2:0]  mf;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = 32'h0; in_pc = 64'h0;

        // Pin the reference decoder with hand-computed values.
        mdec(32'hFFF00093, 32, mi, mf); check("model_addi", {mf, mi}, {3'd1, 64'h0000_0000_FFFF_FFFF});
        mdec(32'hFE000CE3, 64, mi, mf); check("model_beq",  {mf, mi}, {3'd3, 64'hFFFF_FFFF_FFFF_FFF8});
        mdec(32'h0010006F, 32, mi, mf); check("model_jal",  {mf, mi}, {3'd5, 64'h800});
        mdec(32'h800000B7, 64, mi, mf); check("model_lui",  {mf, mi}, {3'd4, 64'hFFFF_FFFF_8000_0000});
        mdec(32'h0007D073, 64, mi, mf); check("model_zimm", {mf, mi}, {3'd1, 64'hF});
        mdec(32'h0000001B, 32, mi, mf); check("model_w32",  {mf, mi}, {3'd7, 64'h0});

        #12;
        check("rst_valid", v32, 1'b0);
        check("rst_ready", r32, 1'b1);
        rst_n = 1'b1;
        tick;

        // Single addi.
        out_ready = 1'b1;
        offer(32'hFFF00093, 64'h100);
        tick;
        check("addi_valid", v32, 1'b1);
        check("addi_imm", imm32, 32'hFFFFFFFF);
        check("addi_fmt", {ill32, fmt32}, {1'b0, 3'd1});

        // Back-to-back sw, beq, jal.
        offer(32'hFE112E23, 64'h104); tick;
        check("sw_imm", {fmt32, imm32}, {3'd2, 32'hFFFFFFFC});
        check("sw_pc", pc32, 32'h104);
        offer(32'hFE000CE3, 64'h108); tick;
        check("beq_imm", {fmt32, imm32}, {3'd3, 32'hFFFFFFF8});
        check("beq_pc", pc32, 32'h108);
        offer(32'h0010006F, 64'h10C); tick;
        check("jal_imm", {fmt32, imm32}, {3'd5, 32'h00000800});
        check("jal_pc", pc32, 32'h10C);

        // XLEN-dependent decode.
        offer(32'h800000B7, 64'h110); tick;
        check("lui64", {fmt64, imm64}, {3'd4, 64'hFFFF_FFFF_8000_0000});
        offer(32'h0000001B, 64'h114); tick;
        check("opimm32_64", fmt64, 3'd1);
        check("opimm32_32", {ill32, fmt32, imm32}, {1'b1, 3'd7, 32'h0});
        in_valid = 1'b0; tick;

        // Stall: two accepted, third held off until release.
        out_ready = 1'b0;
        offer(32'h00500113, 64'h200); tick;
        offer(32'h00A00193, 64'h204); tick;
        check("stall_ready", r32, 1'b0);
        offer(32'h00F00213, 64'h208); tick; tick;
        check("stall_hold", {ins32, imm32}, {32'h00500113, 32'h5});
        out_ready = 1'b1; tick;
        check("release_b", ins32, 32'h00A00193);
        tick;
        check("release_c", ins32, 32'h00F00213);
        in_valid = 1'b0; tick;
        check("drained", v32, 1'b0);

        // Flush in TWO beats concurrent accept and pop.
        out_ready = 1'b0;
        offer(32'h00100093, 64'h300); tick;
        offer(32'h00200093, 64'h304); tick;
        flush = 1'b1; out_ready = 1'b1; offer(32'h00300093, 64'h308); tick;
        check("flush_valid", v32, 1'b0);
        check("flush_ready", r32, 1'b1);
        flush = 1'b0; in_valid = 1'b0; tick;

        // Illegal zero word, then asynchronous reset while holding it.
        out_ready = 1'b0;
        offer(32'h00000000, 64'h400); tick;
        check("zero_ill", {v32, ill32, fmt32}, {1'b1, 1'b1, 3'd7});
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_valid32", v32, 1'b0);
        check("async_valid64", v64, 1'b0);
        @(negedge clk); #2 rst_n = 1'b1;
        tick;
        check("post_rst_ready", r32, 1'b1);
        check("post_rst_zero", {imm32, fmt32, ill32, ins32, pc32}, 64'h0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            flush     = ($urandom_range(49) == 0);
            in_instr  = rand_instr();
            in_pc     = {$urandom, $urandom};
            tick;
        end
        in_valid = 1'b0; flush = 1'b0;
        tick; tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
